// File: rtl/adder_8bit_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_8bit_sequencer : byte-serial BYTES*8-bit add/sub over a shared 8-bit adder
// Revision: 1.0
// ---------------------------------------------------------------------------
module adder_8bit_sequencer #(
  parameter int BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [8*BYTES-1:0]   op_a,
  input  logic [8*BYTES-1:0]   op_b,
  input  logic                 c_in,
  input  logic                 sub,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  output logic                 add_c_in,
  input  logic [7:0]           add_sum,
  input  logic                 add_c_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [8*BYTES-1:0]   result,
  output logic                 c_out,
  output logic                 busy
);

  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [BYTES-1:0][7:0]    a_q, a_d;
  logic [BYTES-1:0][7:0]    b_q, b_d;
  logic [BYTES-1:0][7:0]    result_q, result_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     carry_q, carry_d;
  logic                     c_out_q, c_out_d;
  logic [7:0]               lane_a, lane_b;

  // Lane select written as a compare loop so any BYTES (not only powers of two) is legal.
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        lane_a = a_q[i];
        lane_b = b_q[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    c_out_d  = c_out_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d      = op_a;
          b_d      = sub ? ~op_b : op_b;
          carry_d  = sub | c_in;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < BYTES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            result_d[i] = add_sum;
          end
        end
        carry_d = add_c_out;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          c_out_d = add_c_out;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      c_out_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      c_out_q  <= c_out_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign add_a       = (state_q == RUN) ? lane_a : 8'h00;
  assign add_b       = (state_q == RUN) ? lane_b : 8'h00;
  assign add_c_in    = (state_q == RUN) ? carry_q : 1'b0;
  assign result      = result_q;
  assign c_out       = c_out_q;

endmodule
`default_nettype wire

// File: doc/adder_8bit_sequencer.md
# adder_8bit_sequencer

Multi-cycle controller that computes a BYTES×8-bit add or subtract on a single shared combinational `full_adder_8bit`. It processes one byte lane per clock, least-significant first, and chains the carry through an internal register. It sits between a valid/ready command source and the external adder instance, which it drives over a dedicated adder port group.

## Interface

Parameters:
- `BYTES`, default 4: operand width in bytes; legal range ≥ 1. The byte index counter is $clog2(BYTES) bits wide, with a minimum of 1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start_valid`  in  1  command offered.
- `start_ready`  out  1  sequencer can accept a command (IDLE only).
- `op_a`  in  8*BYTES  operand A, sampled on accept.
- `op_b`  in  8*BYTES  operand B, sampled on accept.
- `c_in`  in  1  carry-in for add, sampled on accept; ignored when `sub`=1.
- `sub`  in  1  0 = A+B+c_in; 1 = A−B (A + ~B + 1), sampled on accept.
- `add_a`  out  8  byte lane of A to the adder.
- `add_b`  out  8  byte lane of B (inverted when `sub`) to the adder.
- `add_c_in`  out  1  carry to the adder.
- `add_sum`  in  8  adder sum, combinational from `add_*`.
- `add_c_out`  in  1  adder carry-out.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes result.
- `result`  out  8*BYTES  assembled sum/difference.
- `c_out`  out  1  final carry. For `sub`, 1 = no borrow (A ≥ B).
- `busy`  out  1  high in RUN or DONE.

## Operation

- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `start_ready`=1.
  - On `start_valid`&&`start_ready`, latch `op_a` and `op_b`. Latch `op_b` inverted when `sub`=1.
  - Load the carry register with `sub ? 1 : c_in`, set idx=0 and go to RUN.
  - Clear `result` to 0 on accept.
- **RUN**
  - Drive `add_a`=A[8*idx+:8], `add_b`=B'[8*idx+:8] and `add_c_in`=carry register.
  - Each edge, write `add_sum` into `result[8*idx+:8]`, load carry ← `add_c_out`, and increment idx.
  - When idx==BYTES−1, the capture edge also sets `c_out` ← `add_c_out`, moves to DONE and asserts `res_valid`.
- **DONE**
  - `res_valid`=1. `result` and `c_out` are held stable until `res_ready`=1.
  - On the handshake edge, go to IDLE and deassert `res_valid`.
  - `start_valid` is ignored; there is no bypass from DONE to RUN.
- Outside RUN, `add_a`, `add_b` and `add_c_in` are driven 0.
- Arithmetic is modulo 2^(8*BYTES). Overflow beyond `c_out` is not reported. Signed overflow is not computed.
- `start_valid` is not required to stay high once the command is accepted. Operand inputs are don't-care outside the accept edge.

## Timing

- Reset values (any edge with `rst_n`=0): state IDLE, `start_ready`=1, `res_valid`=0, `busy`=0, `result`=0, `c_out`=0, `add_a`/`add_b`/`add_c_in`=0, idx=0, carry register=0.
- Reset has priority over every other event. Reset asserted mid-RUN or in DONE aborts the operation, discards the partial result and produces no `res_valid` pulse.
- Latency: accept at edge E0; bytes 0..BYTES−1 are captured on edges E1..E_BYTES; `res_valid` is high from E_BYTES.
- Throughput: with `res_ready` held high, result handshake is at E_BYTES+1. The next accept is no earlier than E_BYTES+2, giving a minimum period of BYTES+2 cycles.
- Adder path: `add_*` out → `add_sum`/`add_c_out` in is a same-cycle combinational loop through the external adder. It must close within one clock period.
- BYTES=1: a single RUN cycle; idx stays 0.

## Test plan

- **Add with internal carry**: BYTES=4, A=0x000000FF, B=0x00000001, c_in=0, sub=0 → `result`=0x00000100, `c_out`=0. `res_valid` rises exactly 4 edges after accept.
- **Full carry ripple**: A=0xFFFFFFFF, B=0x00000000, c_in=1 → `result`=0x00000000, `c_out`=1. Also check `add_c_in`=1 in every RUN cycle.
- **Subtract with borrow**: sub=1, A=0x00000005, B=0x00000007 → `result`=0xFFFFFFFE, `c_out`=0. With A=7, B=5 → `result`=0x00000002, `c_out`=1.
- **Backpressure**: hold `res_ready`=0 for 10 cycles after `res_valid` while pulsing `start_valid` with new operands. `result` and `c_out` must stay constant, `start_ready` must stay 0, and the new command must not be accepted.
- **Reset mid-operation**: drop `rst_n` for one edge while idx=2. All outputs must return to reset values next cycle with no `res_valid`. A following A=100, B=30 must give 130.
- **Back-to-back**: `start_valid` and `res_ready` held high, operands (1,2) then (3,4) → results 3 then 7, with accepts 6 cycles apart (BYTES+2).
- **Random sweep**: random sweep against the reference model A+B+c_in / A−B, with BYTES=1 and BYTES=4.
